// File: rtl/intr_sequencer_if.sv
// Handshake bus between the interrupt sequencer and the core datapath:
// stack push, ISR vector read from data memory, and PC redirect.
interface intr_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              push_req;
    logic [ADDR_W-1:0] push_data;
    logic              push_ack;
    logic              vec_rd_req;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_rd_ack;
    logic [ADDR_W-1:0] vec_rd_data;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;

    modport master (
        output push_req, push_data, vec_rd_req, vec_addr, pc_load, pc_load_value,
        input  push_ack, vec_rd_ack, vec_rd_data
    );

    modport slave (
        input  push_req, push_data, vec_rd_req, vec_addr, pc_load, pc_load_value,
        output push_ack, vec_rd_ack, vec_rd_data
    );
endinterface

// File: rtl/intr_sequencer.sv
// Interrupt entry/exit controller: synchronises the pin, waits for a safe point,
// flushes, pushes the return PC, fetches the ISR vector, redirects, and restores CCR on RTI.
module intr_sequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(8'h01),
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_in,
    input  logic              pipe_busy,
    input  logic [ADDR_W-1:0] resume_pc,
    input  logic [3:0]        ccr_in,
    input  logic              rti_commit,
    output logic              pc_hold,
    output logic              flush,
    output logic              ccr_restore,
    output logic [3:0]        saved_ccr,
    output logic              in_isr,
    output logic              intr_pending,
    intr_sequencer_if.master  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_FLUSH    = 3'd2;
    localparam logic [2:0] S_PUSH     = 3'd3;
    localparam logic [2:0] S_VEC      = 3'd4;
    localparam logic [2:0] S_REDIRECT = 3'd5;
    localparam logic [2:0] S_ISR      = 3'd6;
    localparam logic [2:0] S_RESTORE  = 3'd7;

    logic [2:0]             state;
    logic [2:0]             state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise_c;
    logic [ADDR_W-1:0]      ret_pc;
    logic [ADDR_W-1:0]      vec_q;

    assign rise_c            = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign bus.push_data     = ret_pc;
    assign bus.pc_load_value = vec_q;

    // Pin synchroniser and rising-edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], intr_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    // Sticky request; a fresh edge outranks the clear at redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_pending <= 1'b0;
        end else if (rise_c) begin
            intr_pending <= 1'b1;
        end else if (state == S_REDIRECT) begin
            intr_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (intr_pending && !in_isr) state_nx = S_WAIT;
            S_WAIT:     if (!pipe_busy)              state_nx = S_FLUSH;
            S_FLUSH:                                 state_nx = S_PUSH;
            S_PUSH:     if (bus.push_ack)            state_nx = S_VEC;
            S_VEC:      if (bus.vec_rd_ack)          state_nx = S_REDIRECT;
            S_REDIRECT:                              state_nx = S_ISR;
            S_ISR:      if (rti_commit)              state_nx = S_RESTORE;
            S_RESTORE:                               state_nx = S_IDLE;
            default:                                 state_nx = S_IDLE;
        endcase
    end

    // Control outputs registered off the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_hold        <= 1'b0;
            flush          <= 1'b0;
            bus.push_req   <= 1'b0;
            bus.vec_rd_req <= 1'b0;
            bus.vec_addr   <= '0;
            bus.pc_load    <= 1'b0;
            ccr_restore    <= 1'b0;
            in_isr         <= 1'b0;
        end else begin
            pc_hold        <= (state_nx == S_WAIT) || (state_nx == S_FLUSH) ||
                              (state_nx == S_PUSH) || (state_nx == S_VEC);
            flush          <= (state_nx == S_FLUSH);
            bus.push_req   <= (state_nx == S_PUSH);
            bus.vec_rd_req <= (state_nx == S_VEC);
            bus.vec_addr   <= (state_nx == S_VEC) ? VECTOR_ADDR : '0;
            bus.pc_load    <= (state_nx == S_REDIRECT);
            ccr_restore    <= (state_nx == S_RESTORE);
            in_isr         <= (state_nx == S_ISR) || (state_nx == S_RESTORE);
        end
    end

    // Context captured at the safe point and the fetched vector
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_pc    <= '0;
            saved_ccr <= 4'b0;
            vec_q     <= '0;
        end else begin
            if (state == S_WAIT && !pipe_busy) begin
                ret_pc    <= resume_pc;
                saved_ccr <= ccr_in;
            end
            if (state == S_VEC && bus.vec_rd_ack) begin
                vec_q <= bus.vec_rd_data;
            end
        end
    end

endmodule
